// File: rtl/cla_word_sequencer_pkg.sv
// rtl/cla_word_sequencer_pkg.sv - shared constants, state encoding and width check for the CLA word sequencer
`define CWS_WIDTH_OK(w) ((((w) % 4) == 0) && ((w) >= 8))

package cla_word_sequencer_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_word_sequencer_if.sv
// rtl/cla_word_sequencer_if.sv - request/response handshake bundle for the CLA word sequencer
interface cla_word_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, c_out, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, c_out, ovf, busy
  );
endinterface

// File: rtl/cla_word_sequencer_cla4_slice.sv
// rtl/cla_word_sequencer_cla4_slice.sv - combinational 4-bit carry-lookahead adder slice
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:1] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g/p and c_in, so no carry waits on another.
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign sum   = p ^ {c[3], c[2], c[1], c_in};
  assign c_out = c[4];
endmodule

// File: rtl/cla_word_sequencer.sv
// rtl/cla_word_sequencer.sv - multi-cycle add/subtract engine reusing one 4-bit CLA slice per nibble
import cla_word_sequencer_pkg::*;

module cla_word_sequencer #(
  parameter int WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  cla_word_sequencer_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if (!`CWS_WIDTH_OK(WIDTH)) begin : g_bad_width
      $error("cla_word_sequencer: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_t             state;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   result_q;
  logic               carry;
  logic               c_out_q;
  logic               ovf_q;
  logic [IDX_W-1:0]   idx;

  logic [SLICE_W-1:0] a_nib;
  logic [SLICE_W-1:0] b_nib;
  logic [SLICE_W-1:0] s_nib;
  logic               s_cout;
  logic               c_into_msb;

  assign a_nib = op_a[idx*SLICE_W +: SLICE_W];
  assign b_nib = op_b[idx*SLICE_W +: SLICE_W];

  cla4_slice u_slice (
    .a     (a_nib),
    .b     (b_nib),
    .c_in  (carry),
    .sum   (s_nib),
    .c_out (s_cout)
  );

  // Carry into the word MSB, recovered from the top nibble's bit-3 operands and sum.
  assign c_into_msb = a_nib[SLICE_W-1] ^ b_nib[SLICE_W-1] ^ s_nib[SLICE_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      result_q <= '0;
      carry    <= 1'b0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a  <= bus.a;
            op_b  <= bus.b ^ {WIDTH{bus.sub}};
            carry <= bus.sub;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result_q[idx*SLICE_W +: SLICE_W] <= s_nib;
          carry <= s_cout;
          if (idx == LAST_IDX) begin
            c_out_q <= s_cout;
            ovf_q   <= c_into_msb ^ s_cout;
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.result    = result_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// tb/tb_cla_word_sequencer.sv - randomized self-checking bench for cla_word_sequencer
module tb_cla_word_sequencer;
  localparam int WIDTH = 16;
  localparam int NSLICE = WIDTH / 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cla_word_sequencer_if #(.WIDTH(WIDTH)) bus ();

  cla_word_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result from plain integer arithmetic on the operands.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output logic [15:0] r, output logic co, output logic ov);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'(shortint'(a));
    int sb = int'(shortint'(b));
    int sr;
    if (s) begin
      r  = 16'(ua - ub);
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = 16'(ua + ub);
      co = (ua + ub) > 65535;
      sr = sa + sb;
    end
    ov = (sr > 32767) || (sr < -32768);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input int hold);
    logic [15:0] er;
    logic        eco;
    logic        eov;
    model(a, b, s, er, eco, eov);
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.a = a;
    bus.b = b;
    bus.sub = s;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.sub = 1'($urandom);
    chk("busy_run", bus.busy, 1);
    for (int k = 1; k <= NSLICE; k++) begin
      @(posedge clk);
      #1;
      chk("out_valid_lat", bus.out_valid, 32'(k == NSLICE));
    end
    chk("result", bus.result, er);
    chk("c_out", bus.c_out, eco);
    chk("ovf", bus.ovf, eov);
    chk("in_ready_done", bus.in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      bus.sub = 1'($urandom);
      @(posedge clk);
      #1;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_result", {bus.c_out, bus.ovf, bus.result}, {eco, eov, er});
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("out_valid_clr", bus.out_valid, 0);
    chk("busy_idle", bus.busy, 0);
    chk("result_retained", {bus.c_out, bus.ovf, bus.result}, {eco, eov, er});
  endtask

  logic [15:0] dir_a [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h8000};
  logic [15:0] dir_b [6] = '{16'h0FED, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h8000};
  logic        dir_s [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_outputs", {bus.c_out, bus.ovf, bus.result}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_op(dir_a[i], dir_b[i], dir_s[i], (i == 0) ? 5 : 0);

    // Abort an operation two cycles after it was accepted.
    @(negedge clk);
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_valid", bus.out_valid, 0);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cla_word_sequencer.md
Name: cla_word_sequencer

Overview:
Multi-cycle WIDTH-bit add/subtract engine built around a single 4-bit carry-lookahead slice, which it reuses once per nibble, least-significant nibble first. A valid/ready request interface accepts operands and a valid/ready response interface returns the result. The block serves arithmetic clients that can trade latency for area: one CLA slice replaces a full-width adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
NSLICE, WIDTH/4, derived localparam; number of slice passes per operation (not overridable).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum/difference (registered)
c_out  output  1  carry out of MSB; for subtract, 1 = no borrow
ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, result=0, c_out=0, ovf=0, busy=0. in_ready=1 once reset is applied, since it decodes state.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE), combinational from state. out_valid = (state==DONE).
- IDLE, on in_valid & in_ready:
  - latch a into op_a.
  - latch b XOR {WIDTH{sub}} into op_b.
  - carry register <= sub.
  - slice index <= 0.
  - -> RUN.
  - Without a request, stay in IDLE.
- RUN, each cycle:
  - slice computes op_a[4i+3:4i] + op_b[4i+3:4i] + carry.
  - sum nibble is written to result[4i+3:4i]; carry <= slice carry out; i <= i+1.
  - When i==NSLICE-1: c_out <= slice carry out; ovf <= (carry into bit 3 of slice) XOR (slice carry out), where carry into bit 3 = op_a[MSB]^op_b[MSB]^sum[MSB]; -> DONE.
- DONE:
  - result, c_out and ovf are held stable while out_ready=0; in_valid is ignored.
  - On out_ready: -> IDLE.
  - result/c_out/ovf retain their values after the handshake until the next operation overwrites them.
- Latency: out_valid rises exactly NSLICE cycles after the accepting clock edge (4 for WIDTH=16).
- Throughput: at most one operation per NSLICE+2 cycles. No back-to-back acceptance in DONE.
- Operands are captured at acceptance; a and b may change during RUN without effect.
- result nibbles above the current index may hold stale data during RUN. Only DONE values are meaningful.
- Width rules: all arithmetic is modulo 2^WIDTH. No sign extension.
- Reset mid-operation (RUN or DONE): aborts immediately, no out_valid pulse, all outputs take their reset values.
- Slice index counter is $clog2(NSLICE) bits wide and must never exceed NSLICE-1.

Decomposition:
- Shared package/include:
  - SLICE_W=4.
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - WIDTH legality check macro (multiple of 4, >=8).
- One sub-module: cla4_slice, a purely combinational 4-bit carry-lookahead adder with ports a[3:0], b[3:0], c_in, sum[3:0], c_out, using generate/propagate lookahead with no ripple. The sequencer adds only the FSM, operand registers, nibble mux and result write-back.

Test Plan:
- Basic add, no carry: WIDTH=16, a=0x1234, b=0x0FED, sub=0 -> result=0x2221, c_out=0, ovf=0; out_valid rises 4 cycles after acceptance.
- Carry propagation across all slices: a=0xFFFF, b=0x0001, sub=0 -> result=0x0000, c_out=1, ovf=0.
- Signed overflow on add and subtract:
  - a=0x7FFF+0x0001 -> 0x8000, c_out=0, ovf=1.
  - a=0x8000, b=0x0001, sub=1 -> 0x7FFF, c_out=1, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, c_out=0, ovf=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> result/c_out/ovf unchanged, in_ready=0, no new acceptance. Release out_ready -> IDLE; the next request is accepted the following cycle.
- Reset mid-RUN: assert rst asynchronously 2 cycles after acceptance -> out_valid=0, result=0, busy=0, in_ready=1 immediately. No out_valid pulse follows. The next operation (0x0001+0x0001) returns 0x0002.
